// File: rtl/projectile_grid.sv
// projectile_grid
//   Bitmap of live player projectiles, COLS columns by ROWS rows. Each column
//   is an independent shift chain that advances one row per game tick. A
//   rising edge on fire queues one shot at user_x, which is inserted into
//   row 0 at the next tick. A shot entering HIT_ROW in the enemy's column is
//   absorbed and counted.
//
// Ports
//   clock      system clock
//   reset_n    synchronous active-low reset
//   clear      synchronous new-game clear (hit_count is kept)
//   enable     game running; low freezes tick counter and grid
//   fire       raw fire level; only its rising edge counts
//   user_x     player column
//   enemy_x    enemy column
//   grid       bitmap, bit c*ROWS+r = column c, row r
//   tick       one-cycle pulse per game tick (grid updates with it)
//   hit        one-cycle pulse, coincident with tick, on an enemy hit
//   hit_count  saturating hit counter
//   ready      a fire edge would be accepted now
module projectile_grid #(
  parameter int COLS     = 160,
  parameter int ROWS     = 120,
  parameter int XW       = 8,
  parameter int TICK_DIV = 3125000,
  parameter int CNT_W    = 22,
  parameter int COOLDOWN = 4,
  parameter int HIT_ROW  = 100,
  parameter int HITS_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 fire,
  input  logic [XW-1:0]        user_x,
  input  logic [XW-1:0]        enemy_x,
  output logic [COLS*ROWS-1:0] grid,
  output logic                 tick,
  output logic                 hit,
  output logic [HITS_W-1:0]    hit_count,
  output logic                 ready
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(COOLDOWN);

  logic [COLS*ROWS-1:0] grid_q, grid_d;
  logic                 tick_q, tick_d;
  logic                 hit_q, hit_d;
  logic                 pending_q, pending_d;
  logic [CD_W-1:0]      cooldown_q, cooldown_d;
  logic [HITS_W-1:0]    hit_count_q, hit_count_d;
  logic                 fire_q, fire_d;
  logic [XW-1:0]        shot_x_q, shot_x_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 tick_now;
  logic                 ready_now;
  logic                 user_ok;
  logic                 accept;
  logic                 hit_now;
  logic [COLS-1:0]      hit_col;
  logic [COLS*ROWS-1:0] grid_shift;

  // The tick is decided combinationally from the counter; all tick effects
  // commit on the same edge that raises tick_q, so tick/hit are seen
  // together with the already-updated grid.
  assign tick_now  = enable && (cnt_q == '0);
  assign ready_now = !pending_q && (cooldown_q == '0);
  assign user_ok   = {1'b0, user_x} < (XW+1)'(COLS);
  assign accept    = fire && !fire_q && ready_now && user_ok;

  // Per-column shift with insertion at row 0 and absorption at HIT_ROW.
  // An out-of-range enemy_x matches no column, so no hit is detected.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic            ins_bit;
    logic [ROWS-1:0] col_q;
    logic [ROWS-1:0] absorb_mask;

    assign col_q       = grid_q[gi*ROWS +: ROWS];
    assign ins_bit     = pending_q && (shot_x_q == XW'(gi));
    assign hit_col[gi] = col_q[HIT_ROW-1] && (enemy_x == XW'(gi));
    assign absorb_mask = hit_col[gi] ? (ROWS'(1) << HIT_ROW) : '0;
    assign grid_shift[gi*ROWS +: ROWS] = {col_q[ROWS-2:0], ins_bit} & ~absorb_mask;
  end

  assign hit_now = |hit_col;

  always_comb begin
    grid_d      = grid_q;
    tick_d      = 1'b0;
    hit_d       = 1'b0;
    pending_d   = pending_q;
    cooldown_d  = cooldown_q;
    hit_count_d = hit_count_q;
    fire_d      = fire;
    shot_x_d    = shot_x_q;
    cnt_d       = cnt_q;

    if (enable) begin
      cnt_d = tick_now ? CNT_RELOAD : cnt_q - CNT_W'(1);
    end

    // accept needs pending_q=0 and insertion needs pending_q=1, so the two
    // never fight over pending_d; a same-cycle accept waits for the next tick.
    if (accept) begin
      pending_d = 1'b1;
      shot_x_d  = user_x;
    end

    if (tick_now) begin
      tick_d = 1'b1;
      grid_d = grid_shift;
      hit_d  = hit_now;
      if (hit_now && (hit_count_q != '1)) begin
        hit_count_d = hit_count_q + HITS_W'(1);
      end
      if (pending_q) begin
        pending_d  = 1'b0;
        cooldown_d = CD_LOAD;
      end else if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - CD_W'(1);
      end
    end

    if (clear) begin
      grid_d     = '0;
      pending_d  = 1'b0;
      cooldown_d = '0;
      hit_d      = 1'b0;
      tick_d     = 1'b0;
      cnt_d      = CNT_RELOAD;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grid_q      <= '0;
      tick_q      <= 1'b0;
      hit_q       <= 1'b0;
      pending_q   <= 1'b0;
      cooldown_q  <= '0;
      hit_count_q <= '0;
      fire_q      <= 1'b0;
      shot_x_q    <= '0;
      cnt_q       <= CNT_RELOAD;
    end else begin
      grid_q      <= grid_d;
      tick_q      <= tick_d;
      hit_q       <= hit_d;
      pending_q   <= pending_d;
      cooldown_q  <= cooldown_d;
      hit_count_q <= hit_count_d;
      fire_q      <= fire_d;
      shot_x_q    <= shot_x_d;
      cnt_q       <= cnt_d;
    end
  end

  assign grid      = grid_q;
  assign tick      = tick_q;
  assign hit       = hit_q;
  assign hit_count = hit_count_q;
  assign ready     = ready_now;

endmodule

// File: tb/tb_projectile_grid.sv
// Testbench for projectile_grid with an 8x6 grid, TICK_DIV=4, COOLDOWN=2,
// HIT_ROW=4. Stimulus pushes the expected state for each upcoming tick into
// a queue; a monitor pops and compares whenever the DUT pulses tick.
module tb_projectile_grid;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int XW   = 4;
  localparam int GW   = COLS * ROWS;

  typedef struct packed {
    logic [GW-1:0] g;
    logic          h;
    logic [7:0]    hc;
    logic          rdy;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic          clear;
  logic          enable;
  logic          fire;
  logic [XW-1:0] user_x;
  logic [XW-1:0] enemy_x;
  logic [GW-1:0] grid;
  logic          tick;
  logic          hit;
  logic [7:0]    hit_count;
  logic          ready;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  projectile_grid #(
    .COLS(COLS), .ROWS(ROWS), .XW(XW), .TICK_DIV(4), .CNT_W(2),
    .COOLDOWN(2), .HIT_ROW(4), .HITS_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
    .fire(fire), .user_x(user_x), .enemy_x(enemy_x), .grid(grid),
    .tick(tick), .hit(hit), .hit_count(hit_count), .ready(ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [GW-1:0] gb(input int c, input int r);
    gb = (r < ROWS) ? (GW'(1) << (c*ROWS + r)) : '0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Queue the expected state for the next tick, then wait for it; the tick
  // must arrive exactly n cycles from now.
  task automatic tick_expect(input logic [GW-1:0] g, input logic h,
                             input logic [7:0] hc, input logic rdy, input int n);
    int   k;
    logic seen;
    exp_t e;
    e.g = g; e.h = h; e.hc = hc; e.rdy = rdy;
    sb.push_back(e);
    k = 0;
    seen = 1'b0;
    while (!seen && k < n + 8) begin
      step();
      k++;
      if (tick) seen = 1'b1;
    end
    if (!seen) check("tick_timeout", 64'(seen), 64'(1));
    else       check("tick_spacing", 64'(k), 64'(n));
  endtask

  task automatic fire_edge(input logic [XW-1:0] x);
    fire = 1'b1;
    user_x = x;
    step();
    fire = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (tick === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_tick", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check("grid", 64'(grid), 64'(mon_e.g));
          check("hit", 64'(hit), 64'(mon_e.h));
          check("hit_count", 64'(hit_count), 64'(mon_e.hc));
          check("ready", 64'(ready), 64'(mon_e.rdy));
        end
      end else begin
        check("hit_idle", 64'(hit), 64'(0));
      end
    end
  end

  initial begin
    int hc;
    int tk;
    reset_n = 1'b0; clear = 1'b0; enable = 1'b1; fire = 1'b0;
    user_x = '0; enemy_x = 4'd7;
    repeat (2) step();
    reset_n = 1'b1;
    check("rst_grid", 64'(grid), 64'(0));
    check("rst_tick", 64'(tick), 64'(0));
    check("rst_hit_count", 64'(hit_count), 64'(0));
    check("rst_ready", 64'(ready), 64'(1));

    // Idle ticks every 4th cycle; an out-of-range fire is ignored.
    tick_expect('0, 1'b0, 8'd0, 1'b1, 4);
    tick_expect('0, 1'b0, 8'd0, 1'b1, 4);
    fire_edge(4'd9);
    check("oor_ready", 64'(ready), 64'(1));
    tick_expect('0, 1'b0, 8'd0, 1'b1, 3);

    // x latched at the edge; shot climbs and leaves the screen.
    fire = 1'b1; user_x = 4'd3;
    step();
    fire = 1'b0; user_x = 4'd5;
    tick_expect(gb(3, 0), 1'b0, 8'd0, 1'b0, 3);
    for (int r = 1; r <= 6; r++)
      tick_expect(gb(3, r), 1'b0, 8'd0, (r >= 2), 4);

    // Enemy hit in column 3, absorbed at row 4.
    enemy_x = 4'd3;
    fire_edge(4'd3);
    tick_expect(gb(3, 0), 1'b0, 8'd0, 1'b0, 3);
    tick_expect(gb(3, 1), 1'b0, 8'd0, 1'b0, 4);
    tick_expect(gb(3, 2), 1'b0, 8'd0, 1'b1, 4);
    tick_expect(gb(3, 3), 1'b0, 8'd0, 1'b1, 4);
    tick_expect('0, 1'b1, 8'd1, 1'b1, 4);
    tick_expect('0, 1'b0, 8'd1, 1'b1, 4);

    // Held fire gives one shot; an edge during cooldown is dropped.
    enemy_x = 4'd7;
    fire = 1'b1; user_x = 4'd2;
    step();
    tick_expect(gb(2, 0), 1'b0, 8'd1, 1'b0, 3);
    fire = 1'b0;
    step();
    fire = 1'b1;
    step();
    tick_expect(gb(2, 1), 1'b0, 8'd1, 1'b0, 2);
    tick_expect(gb(2, 2), 1'b0, 8'd1, 1'b1, 4);
    fire = 1'b0; user_x = 4'd6;
    step();
    fire = 1'b1;
    step();
    tick_expect(gb(2, 3) | gb(6, 0), 1'b0, 8'd1, 1'b0, 2);
    fire = 1'b0;
    for (int r = 1; r <= 6; r++)
      tick_expect(gb(2, 3 + r) | gb(6, r), 1'b0, 8'd1, (r >= 2), 4);

    // Freeze mid-flight, then resume from the held count.
    fire_edge(4'd1);
    tick_expect(gb(1, 0), 1'b0, 8'd1, 1'b0, 3);
    step();
    step();
    enable = 1'b0;
    tk = 0;
    repeat (10) begin
      step();
      if (tick) tk++;
    end
    check("frozen_ticks", 64'(tk), 64'(0));
    check("frozen_grid", 64'(grid), 64'(gb(1, 0)));
    check("frozen_ready", 64'(ready), 64'(0));
    enable = 1'b1;
    tick_expect(gb(1, 1), 1'b0, 8'd1, 1'b0, 2);
    tick_expect(gb(1, 2), 1'b0, 8'd1, 1'b1, 4);

    // Clear with a shot in flight and one pending.
    fire_edge(4'd4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_grid", 64'(grid), 64'(0));
    check("clr_ready", 64'(ready), 64'(1));
    check("clr_hit_count", 64'(hit_count), 64'(1));
    check("clr_tick", 64'(tick), 64'(0));
    tick_expect('0, 1'b0, 8'd1, 1'b1, 4);

    // Drive hit_count to 255 and one beyond.
    enemy_x = 4'd0;
    hc = 1;
    for (int i = 0; i < 255; i++) begin
      fire_edge(4'd0);
      tick_expect(gb(0, 0), 1'b0, 8'(hc), 1'b0, 3);
      tick_expect(gb(0, 1), 1'b0, 8'(hc), 1'b0, 4);
      tick_expect(gb(0, 2), 1'b0, 8'(hc), 1'b1, 4);
      tick_expect(gb(0, 3), 1'b0, 8'(hc), 1'b1, 4);
      hc = (hc == 255) ? 255 : hc + 1;
      tick_expect('0, 1'b1, 8'(hc), 1'b1, 4);
    end

    // Reset with a pending shot.
    fire_edge(4'd5);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rst2_grid", 64'(grid), 64'(0));
    check("rst2_hit_count", 64'(hit_count), 64'(0));
    check("rst2_ready", 64'(ready), 64'(1));
    check("rst2_tick", 64'(tick), 64'(0));
    check("rst2_hit", 64'(hit), 64'(0));
    tick_expect('0, 1'b0, 8'd0, 1'b1, 4);

    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
